// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared IF/OF pipeline constants, stall codes and field positions
package pipeline_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int IF_W    = PC_W + INSTR_W;

    // IF word layout: {PC, instruction}
    localparam int IF_INSTR_LSB = 0;
    localparam int IF_INSTR_MSB = INSTR_W - 1;
    localparam int IF_PC_LSB    = INSTR_W;
    localparam int IF_PC_MSB    = IF_W - 1;

    // Stall codes driven by operand_fetch; 2'b11 behaves like HOLD
    localparam logic [1:0] STALL_RUN    = 2'b00;
    localparam logic [1:0] STALL_HOLD   = 2'b01;
    localparam logic [1:0] STALL_BUBBLE = 2'b10;

    localparam logic [IF_W-1:0] NOP_WORD = 24'd0;

    // Branch update bus: {target PC, taken}
    localparam int BR_W          = PC_W + 1;
    localparam int BR_TAKEN_BIT  = 0;
    localparam int BR_TARGET_LSB = 1;
    localparam int BR_TARGET_MSB = PC_W;

    // Only the RUN code lets the head entry move to OF
    function automatic logic stall_is_run(input logic [1:0] code);
        return code == STALL_RUN;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// rtl/sync_fifo_ptr.sv - head/tail/occupancy bookkeeping for a circular FIFO with clear
module sync_fifo_ptr #(
    parameter int DEPTH = 2,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [AW-1:0]    head_o,
    output logic [AW-1:0]    tail_o,
    output logic [OCC_W-1:0] occupancy_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Next pointers: clear wins, otherwise pointers wrap naturally (DEPTH is a power of two)
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push_i) tail_d = tail_q + AW'(1);
            if (pop_i)  head_d = head_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o      = head_q;
    assign tail_o      = tail_q;
    assign occupancy_o = occ_q;
    assign empty_o     = (occ_q == '0);
    assign full_o      = (occ_q == OCC_W'(DEPTH));

endmodule

// File: rtl/if_of_buffer.sv
// rtl/if_of_buffer.sv - IF/OF pipeline FIFO with stall, bubble and branch flush handling
module if_of_buffer #(
    parameter int DEPTH        = 2,
    parameter int PC_W         = 8,
    parameter int INSTR_W      = 16,
    parameter int FLUSH_SHADOW = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PC_W+INSTR_W-1:0]    IF_output,
    input  logic                       if_valid,
    input  logic [PC_W:0]              Branch_Update_with_isBranch,
    input  logic [1:0]                 stalling_control_signal,
    output logic [PC_W+INSTR_W-1:0]    IfOf,
    output logic                       ifof_valid,
    output logic                       if_hold,
    output logic [$clog2(DEPTH):0]     occupancy
);
    import pipeline_pkg::*;

    localparam int W     = PC_W + INSTR_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int SH_W  = (FLUSH_SHADOW > 0) ? $clog2(FLUSH_SHADOW + 1) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    head, tail;
    logic [OCC_W-1:0] occ;
    logic             empty, full;

    logic [SH_W-1:0]  shadow_q, shadow_d;
    logic [W-1:0]     ifof_q, ifof_d;
    logic             ifof_valid_q, ifof_valid_d;

    logic             branch_taken;
    logic             pop, push_ok;
    logic             push_eff, pop_eff;

    // The target PC is consumed by IF itself; this buffer only reacts to the taken flag
    logic             br_target_unused;
    assign br_target_unused = ^Branch_Update_with_isBranch[BR_TARGET_MSB:BR_TARGET_LSB];

    assign branch_taken = Branch_Update_with_isBranch[BR_TAKEN_BIT];
    assign pop          = stall_is_run(stalling_control_signal) & ~empty;
    assign push_ok      = if_valid & (~full | pop) & (shadow_q == '0);
    assign push_eff     = push_ok & ~branch_taken;
    assign pop_eff      = pop & ~branch_taken;
    assign if_hold      = full & ~pop;

    sync_fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .OCC_W (OCC_W)
    ) u_ptr (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (branch_taken),
        .push_i      (push_eff),
        .pop_i       (pop_eff),
        .head_o      (head),
        .tail_o      (tail),
        .occupancy_o (occ),
        .empty_o     (empty),
        .full_o      (full)
    );

    // Entry storage: written at tail on an accepted push, never cleared
    always_ff @(posedge clk) begin
        if (push_eff) mem_q[tail] <= IF_output;
    end

    // Next output word and wrong-path shadow; a taken branch overrides everything
    always_comb begin
        ifof_d       = ifof_q;
        ifof_valid_d = ifof_valid_q;
        shadow_d     = shadow_q;
        if (branch_taken) begin
            ifof_d       = W'(NOP_WORD);
            ifof_valid_d = 1'b0;
            shadow_d     = SH_W'(FLUSH_SHADOW);
        end else begin
            if (if_valid && shadow_q != '0) shadow_d = shadow_q - SH_W'(1);
            case (stalling_control_signal)
                STALL_RUN: begin
                    if (pop) begin
                        ifof_d       = mem_q[head];
                        ifof_valid_d = 1'b1;
                    end else begin
                        ifof_d       = W'(NOP_WORD);
                        ifof_valid_d = 1'b0;
                    end
                end
                STALL_BUBBLE: begin
                    ifof_d       = W'(NOP_WORD);
                    ifof_valid_d = 1'b0;
                end
                default: begin
                    ifof_d       = ifof_q;
                    ifof_valid_d = ifof_valid_q;
                end
            endcase
        end
    end

    // Registered output stage and shadow counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifof_q       <= W'(NOP_WORD);
            ifof_valid_q <= 1'b0;
            shadow_q     <= '0;
        end else begin
            ifof_q       <= ifof_d;
            ifof_valid_q <= ifof_valid_d;
            shadow_q     <= shadow_d;
        end
    end

    assign IfOf       = ifof_q;
    assign ifof_valid = ifof_valid_q;
    assign occupancy  = occ;

endmodule
